raiz_iter: RTL and testbench

- Self-contained, parametrised integer square-root accelerator. Successor to the externally-sequenced raiz datapath.
- Contains its own FSM and uses the binary digit-by-digit (restoring) method, retiring 2 radicand bits per cycle. Latency is fixed: N/2 cycles.
- Returns floor(sqrt(x)) and the remainder x - root^2.
- Uses a valid/ready handshake on both input and output, a synchronous flush, and reset-cleared cycle and operation counters.

---
 rtl/raiz_pkg.sv | 16 +
 rtl/raiz_step.sv | 39 +++
 rtl/raiz_iter.sv | 120 ++++++++++++
 tb/tb_raiz_iter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/raiz_pkg.sv
// Shared types and helpers for the iterative integer square-root block.
package raiz_pkg;

  // Controller states: waiting for an operand, iterating, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit iterations for an n-bit radicand (two bits retired per step).
  function automatic int iter_count(input int n);
    return n / 2;
  endfunction

endpackage

// File: rtl/raiz_step.sv
// One restoring square-root iteration: bring down two radicand bits, try to
// subtract {root, 01}, and append the resulting root digit.
module raiz_step #(
  parameter int N = 8
) (
  input  logic [N/2:0]   rem,
  input  logic [N/2-1:0] root,
  input  logic [1:0]     bits,
  output logic [N/2:0]   rem_next,
  output logic [N/2-1:0] root_next
);

  localparam int H = N / 2;

  typedef logic [H:0]   rem_t;
  typedef logic [H-1:0] root_t;

  // Trial value is evaluated at H+3 bits so the compare cannot overflow; the
  // kept remainder always fits back into H+1 bits, and the root MSB dropped
  // by the left shift is zero for every in-range partial root.
  logic [H+2:0] r2;
  logic [H+2:0] t;
  logic         ge;

  // Compare-and-subtract for a single root digit.
  always_comb begin
    r2 = {rem, bits};
    t  = {1'b0, root, 2'b01};
    ge = (r2 >= t);
    if (ge) begin
      rem_next  = rem_t'(r2 - t);
      root_next = root_t'({root, 1'b1});
    end else begin
      rem_next  = rem_t'(r2);
      root_next = root_t'({root, 1'b0});
    end
  end

endmodule

// File: rtl/raiz_iter.sv
// Self-sequenced integer square root: floor(sqrt(x)) and x - root^2, two
// radicand bits per cycle, valid/ready on both sides, flush and counters.
module raiz_iter
  import raiz_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 32
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   data_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N/2-1:0] root,
  output logic [N/2:0]   remainder,
  output logic           busy,
  output logic [CW-1:0]  cycles,
  output logic [CW-1:0]  op_count
);

  localparam int H  = N / 2;
  localparam int IW = (H > 1) ? $clog2(H) : 1;

  if ((N < 2) || ((N % 2) != 0)) begin : g_bad_width
    $fatal(1, "raiz_iter: N must be even and at least 2");
  end

  state_t         state;
  logic [N-1:0]   x_sh;
  logic [IW-1:0]  iter;
  logic [H:0]     rem_next;
  logic [H-1:0]   root_next;

  raiz_step #(
    .N(N)
  ) u_step (
    .rem       (remainder),
    .root      (root),
    .bits      (x_sh[N-1:N-2]),
    .rem_next  (rem_next),
    .root_next (root_next)
  );

  // Controller, datapath registers, handshake flags and result counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      x_sh      <= '0;
      iter      <= '0;
      root      <= '0;
      remainder <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      op_count  <= '0;
    end else if (flush) begin
      // Abandon any operation; the last root/remainder are left in place
      // but out_valid is dropped, so nothing is presented.
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_sh      <= data_in;
            remainder <= '0;
            root      <= '0;
            iter      <= IW'(iter_count(N) - 1);
            state     <= CALC;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        CALC: begin
          remainder <= rem_next;
          root      <= root_next;
          x_sh      <= x_sh << 2;
          if (iter == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            iter <= iter - IW'(1);
          end
        end
        DONE: begin
          // Consumption returns to IDLE only; the next operand is taken a
          // cycle later, once in_ready has risen.
          if (out_ready) begin
            op_count  <= op_count + CW'(1);
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Free-running edge counter, unaffected by flush or the handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycles <= '0;
    end else begin
      cycles <= cycles + CW'(1);
    end
  end

endmodule

// File: tb/tb_raiz_iter.sv
module tb_raiz_iter;

  logic clock = 1'b0;
  logic reset;
  logic flush;

  always #5 clock = ~clock;

  // N=8 instance
  logic        iv8, ir8, ov8, or8, busy8;
  logic [7:0]  d8;
  logic [3:0]  root8;
  logic [4:0]  rem8;
  logic [31:0] cyc8, ops8;

  // N=16 instance
  logic        iv16, ir16, ov16, or16, busy16;
  logic [15:0] d16;
  logic [7:0]  root16;
  logic [8:0]  rem16;
  logic [31:0] cyc16, ops16;

  raiz_iter #(.N(8), .CW(32)) dut8 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(iv8), .in_ready(ir8), .data_in(d8),
    .out_valid(ov8), .out_ready(or8), .root(root8), .remainder(rem8),
    .busy(busy8), .cycles(cyc8), .op_count(ops8)
  );

  raiz_iter #(.N(16), .CW(32)) dut16 (
    .clock(clock), .reset(reset), .flush(1'b0),
    .in_valid(iv16), .in_ready(ir16), .data_in(d16),
    .out_valid(ov16), .out_ready(or16), .root(root16), .remainder(rem16),
    .busy(busy16), .cycles(cyc16), .op_count(ops16)
  );

  int checks = 0;
  int errors = 0;
  int exp_ops8 = 0;
  int exp_ops16 = 0;

  typedef struct {
    logic [7:0] x;
    logic [3:0] r;
    logic [4:0] m;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Full N=8 transaction: accept, latency, result, optional backpressure, consume.
  task automatic op8(input logic [7:0] x, input logic [3:0] er, input logic [4:0] em,
                     input int hold, input bit b2b);
    int n;
    n = 0;
    while (ir8 !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
    chk("in_ready_idle", ir8, 1);
    d8 = x; iv8 = 1'b1; or8 = b2b;
    @(posedge clock); #1;
    if (!b2b) iv8 = 1'b0;
    chk("in_ready_calc", ir8, 0);
    chk("busy_calc", busy8, 1);
    n = 0;
    while (ov8 !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
    chk("latency8", n, 4);
    chk("root8", root8, er);
    chk("rem8", rem8, em);
    chk("in_ready_done", ir8, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      chk("hold_valid", ov8, 1);
      chk("hold_root", root8, er);
      chk("hold_rem", rem8, em);
      chk("hold_in_ready", ir8, 0);
      chk("hold_ops", ops8, exp_ops8);
    end
    or8 = 1'b1;
    @(posedge clock); #1;
    exp_ops8++;
    chk("ops8_consume", ops8, exp_ops8);
    chk("out_valid_after", ov8, 0);
    chk("in_ready_after", ir8, 1);
    if (!b2b) or8 = 1'b0;
  endtask

  task automatic op16(input logic [15:0] x, input logic [7:0] er, input logic [8:0] em);
    int n;
    n = 0;
    while (ir16 !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
    chk("in_ready16", ir16, 1);
    d16 = x; iv16 = 1'b1;
    @(posedge clock); #1;
    iv16 = 1'b0;
    n = 0;
    while (ov16 !== 1'b1 && n < 30) begin @(posedge clock); #1; n++; end
    chk("latency16", n, 8);
    chk("root16", root16, er);
    chk("rem16", rem16, em);
    or16 = 1'b1;
    @(posedge clock); #1;
    or16 = 1'b0;
    exp_ops16++;
    chk("ops16", ops16, exp_ops16);
  endtask

  initial begin
    int n, cnt, r, m, rr;

    tbl[0]  = '{8'd0,   4'd0,  5'd0};
    tbl[1]  = '{8'd1,   4'd1,  5'd0};
    tbl[2]  = '{8'd2,   4'd1,  5'd1};
    tbl[3]  = '{8'd3,   4'd1,  5'd2};
    tbl[4]  = '{8'd4,   4'd2,  5'd0};
    tbl[5]  = '{8'd15,  4'd3,  5'd6};
    tbl[6]  = '{8'd16,  4'd4,  5'd0};
    tbl[7]  = '{8'd50,  4'd7,  5'd1};
    tbl[8]  = '{8'd81,  4'd9,  5'd0};
    tbl[9]  = '{8'd99,  4'd9,  5'd18};
    tbl[10] = '{8'd144, 4'd12, 5'd0};
    tbl[11] = '{8'd200, 4'd14, 5'd4};
    tbl[12] = '{8'd224, 4'd14, 5'd28};
    tbl[13] = '{8'd225, 4'd15, 5'd0};
    tbl[14] = '{8'd255, 4'd15, 5'd30};

    reset = 1'b1; flush = 1'b0;
    iv8 = 1'b0; or8 = 1'b0; d8 = '0;
    iv16 = 1'b0; or16 = 1'b0; d16 = '0;
    #12;
    chk("rst_in_ready", ir8, 1);
    chk("rst_out_valid", ov8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_root", root8, 0);
    chk("rst_rem", rem8, 0);
    chk("rst_cycles", cyc8, 0);
    chk("rst_ops", ops8, 0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    chk("cycles_first", cyc8, 1);
    @(posedge clock); #1;
    chk("cycles_second", cyc8, 2);

    // x=0 then x=1, op_count reaches 2
    op8(8'd0, 4'd0, 5'd0, 0, 1'b0);
    op8(8'd1, 4'd1, 5'd0, 0, 1'b0);
    chk("ops_two", ops8, 2);

    // directed table
    for (int i = 0; i < 15; i++) op8(tbl[i].x, tbl[i].r, tbl[i].m, 0, 1'b0);

    // back-to-back with in_valid and out_ready held high
    op8(8'd255, 4'd15, 5'd30, 0, 1'b1);
    op8(8'd144, 4'd12, 5'd0,  0, 1'b1);
    op8(8'd200, 4'd14, 5'd4,  0, 1'b1);
    iv8 = 1'b0; or8 = 1'b0;

    // backpressure
    op8(8'd50, 4'd7, 5'd1, 5, 1'b0);

    // N=16 corners
    op16(16'd65535, 8'd255, 9'd510);
    op16(16'd65280, 8'd255, 9'd255);

    // flush in IDLE beats in_valid
    flush = 1'b1; iv8 = 1'b1; d8 = 8'd9;
    @(posedge clock); #1;
    flush = 1'b0; iv8 = 1'b0;
    chk("flush_idle_ready", ir8, 1);
    chk("flush_idle_busy", busy8, 0);

    // flush in the second CALC cycle
    d8 = 8'd99; iv8 = 1'b1;
    @(posedge clock); #1;
    iv8 = 1'b0;
    @(posedge clock); #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    chk("flush_calc_ready", ir8, 1);
    chk("flush_calc_busy", busy8, 0);
    chk("flush_calc_ops", ops8, exp_ops8);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (ov8 === 1'b1) cnt++;
    end
    chk("flush_calc_no_valid", cnt, 0);
    op8(8'd81, 4'd9, 5'd0, 0, 1'b0);

    // flush in DONE overrides out_ready
    d8 = 8'd15; iv8 = 1'b1;
    @(posedge clock); #1;
    iv8 = 1'b0;
    n = 0;
    while (ov8 !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
    chk("flush_done_reach", ov8, 1);
    flush = 1'b1; or8 = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0; or8 = 1'b0;
    chk("flush_done_valid", ov8, 0);
    chk("flush_done_ready", ir8, 1);
    chk("flush_done_ops", ops8, exp_ops8);

    // exhaustive N=8 against an independent floor-sqrt model
    for (int x = 0; x < 256; x++) begin
      r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      m = x - r * r;
      op8(x[7:0], r[3:0], m[4:0], 0, 1'b1);
      rr = int'(root8);
      chk("exh_identity", rr * rr + int'(rem8), x);
      chk("exh_bound", (int'(rem8) <= 2 * rr), 1);
    end
    iv8 = 1'b0; or8 = 1'b0;

    // reset mid-CALC
    @(posedge clock); #1;
    d8 = 8'd200; iv8 = 1'b1;
    @(posedge clock); #1;
    iv8 = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk("rstc_in_ready", ir8, 1);
    chk("rstc_out_valid", ov8, 0);
    chk("rstc_busy", busy8, 0);
    chk("rstc_root", root8, 0);
    chk("rstc_rem", rem8, 0);
    chk("rstc_cycles", cyc8, 0);
    chk("rstc_ops", ops8, 0);
    exp_ops8 = 0;
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    chk("rstc_cycles_restart", cyc8, 1);

    // reset mid-DONE
    d8 = 8'd255; iv8 = 1'b1;
    @(posedge clock); #1;
    iv8 = 1'b0;
    n = 0;
    while (ov8 !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
    chk("rstd_reach", ov8, 1);
    reset = 1'b1;
    #1;
    chk("rstd_out_valid", ov8, 0);
    chk("rstd_in_ready", ir8, 1);
    chk("rstd_busy", busy8, 0);
    chk("rstd_root", root8, 0);
    chk("rstd_rem", rem8, 0);
    chk("rstd_cycles", cyc8, 0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    chk("rstd_cycles_restart", cyc8, 1);
    op8(8'd81, 4'd9, 5'd0, 0, 1'b0);
    chk("rstd_ops_after", ops8, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
